ins_seq_dec: RTL

- Sequenced, parametrised instruction decoder for the simple accumulator processor.
- Owns the instruction register and a FETCH/DECODE/EXECUTE phase state machine.
- Decodes the opcode into one-hot datapath strobes, resolves conditional jumps against the Z/C flags, and stretches EXECUTE for I/O handshakes.
- Counts retired instructions. Sits between program memory and the datapath/PC logic.

---
 rtl/ins_seq_dec.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/ins_seq_dec.sv
// Sequenced instruction decoder for the accumulator processor: IR, FETCH/DECODE/EXECUTE FSM, strobes, retire count.
// Latency: 3 cycles per instruction minimum (FETCH, DECODE, EXECUTE); all outputs combinational from state/ir/inputs.
// Backpressure: stall freezes everything; EXECUTE stretches until in_valid (inp) or out_ready (outp).
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   stall               freezes sequencer, IR and counter (highest priority)
//   ir_in, ir_valid     instruction word from program memory and its valid
//   z_flag, c_flag      ALU flags for conditional jumps
//   in_valid, out_ready I/O handshakes that stretch EXECUTE
//   fetch/decode/execute one-hot phase indicators
//   ir                  instruction register
//   load..jumpnc        one-hot class strobes
//   jump_taken, pc_inc  PC control; retire pulses on the final EXECUTE cycle
//   illegal             undefined opcode in DECODE/EXECUTE (executes as NOP)
//   instr_count         retired-instruction counter (wraps)
module ins_seq_dec #(
   parameter int IR_WIDTH      = 8,   // must be >= 8
   parameter int CNT_WIDTH     = 16,
   parameter int DECODE_ASSERT = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 stall,
   input  logic [IR_WIDTH-1:0]  ir_in,
   input  logic                 ir_valid,
   input  logic                 z_flag,
   input  logic                 c_flag,
   input  logic                 in_valid,
   input  logic                 out_ready,
   output logic                 fetch,
   output logic                 decode,
   output logic                 execute,
   output logic [IR_WIDTH-1:0]  ir,
   output logic                 load,
   output logic                 bitand,
   output logic                 add,
   output logic                 sub,
   output logic                 inp,
   output logic                 outp,
   output logic                 jump,
   output logic                 jumpz,
   output logic                 jumpnz,
   output logic                 jumpc,
   output logic                 jumpnc,
   output logic                 jump_taken,
   output logic                 pc_inc,
   output logic                 retire,
   output logic                 illegal,
   output logic [CNT_WIDTH-1:0] instr_count
);

   // One-hot encoding so the phase indicators are straight register bits.
   typedef enum logic [2:0] {
      S_FETCH  = 3'b001,
      S_DECODE = 3'b010,
      S_EXEC   = 3'b100
   } state_t;

   state_t state;

   logic [3:0] opcode;
   logic [1:0] cond;
   logic d_load, d_bitand, d_add, d_sub, d_inp, d_outp;
   logic d_jump, d_jumpz, d_jumpnz, d_jumpc, d_jumpnc;
   logic legal;
   logic strobe_en;
   logic complete;

   assign opcode = ir[IR_WIDTH-1 -: 4];
   assign cond   = ir[IR_WIDTH-5 -: 2];

   // Raw opcode decode, independent of phase.
   always_comb begin
      d_load   = 1'b0;
      d_bitand = 1'b0;
      d_add    = 1'b0;
      d_sub    = 1'b0;
      d_inp    = 1'b0;
      d_outp   = 1'b0;
      d_jump   = 1'b0;
      d_jumpz  = 1'b0;
      d_jumpnz = 1'b0;
      d_jumpc  = 1'b0;
      d_jumpnc = 1'b0;
      legal    = 1'b1;
      case (opcode)
         4'b0000: d_load   = 1'b1;
         4'b0001: d_bitand = 1'b1;
         4'b0100: d_add    = 1'b1;
         4'b0110: d_sub    = 1'b1;
         4'b1000: d_jump   = 1'b1;
         4'b1001: begin
            case (cond)
               2'b00:   d_jumpz  = 1'b1;
               2'b01:   d_jumpnz = 1'b1;
               2'b10:   d_jumpc  = 1'b1;
               default: d_jumpnc = 1'b1;
            endcase
         end
         4'b1010: d_inp    = 1'b1;
         4'b1110: d_outp   = 1'b1;
         default: legal    = 1'b0;
      endcase
   end

   assign fetch   = (state == S_FETCH);
   assign decode  = (state == S_DECODE);
   assign execute = (state == S_EXEC);

   assign strobe_en = execute | ((DECODE_ASSERT != 0) & decode);

   assign load   = strobe_en & d_load;
   assign bitand = strobe_en & d_bitand;
   assign add    = strobe_en & d_add;
   assign sub    = strobe_en & d_sub;
   assign inp    = strobe_en & d_inp;
   assign outp   = strobe_en & d_outp;
   assign jump   = strobe_en & d_jump;
   assign jumpz  = strobe_en & d_jumpz;
   assign jumpnz = strobe_en & d_jumpnz;
   assign jumpc  = strobe_en & d_jumpc;
   assign jumpnc = strobe_en & d_jumpnc;

   assign illegal = (decode | execute) & ~legal;

   // I/O instructions wait for their handshake; everything else (illegal too) completes at once.
   assign complete = d_inp ? in_valid : (d_outp ? out_ready : 1'b1);

   // Uses the raw decode so the result does not depend on DECODE_ASSERT.
   assign jump_taken = execute & (d_jump
                                | (d_jumpz  &  z_flag)
                                | (d_jumpnz & ~z_flag)
                                | (d_jumpc  &  c_flag)
                                | (d_jumpnc & ~c_flag));

   assign retire = execute & complete & ~stall;
   assign pc_inc = retire & ~jump_taken;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_FETCH;
         ir          <= '0;
         instr_count <= '0;
      end else if (!stall) begin
         case (state)
            S_FETCH: begin
               if (ir_valid) begin
                  ir    <= ir_in;
                  state <= S_DECODE;
               end
            end
            S_DECODE: state <= S_EXEC;
            S_EXEC: begin
               if (complete) begin
                  instr_count <= instr_count + CNT_WIDTH'(1);
                  state       <= S_FETCH;
               end
            end
            default: state <= S_FETCH;
         endcase
      end
   end

endmodule
